// File: rtl/ps2_scancode_rx_pkg.sv
// rtl/ps2_scancode_rx_pkg.sv - shared types and constants for the PS/2 scancode receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Bytes following E1 that belong to the Pause sequence and are swallowed
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard status/acknowledge bytes that never form a key event
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - PS/2 pin pair and key event bundle
interface ps2_scancode_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_error;

    // master: board side driving the pins and consuming events
    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_error
    );

    // slave: the receiver
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_error
    );
endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// rtl/ps2_scancode_rx_line_filter.sv - two-flop synchroniser plus saturating counter deglitch
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       level_d;

    // Level flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        cnt_d   = 8'd0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchroniser and filter state; idle line level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 frame receiver and prefix folding into 11-bit key events
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    ps2_scancode_rx_if.slave   ps2
);

    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic clk_f;
    logic data_f;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2.ps2_clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2.ps2_data),
        .level_o (data_f)
    );

    ps2_state_e  state_q;
    logic        clk_prev_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [19:0] to_cnt_q;
    logic        frame_error_q;

    logic        ext_q;
    logic        brk_q;
    logic [2:0]  skip_q;
    logic [10:0] key_q;

    logic sample;
    logic timeout;
    logic start_err;
    logic stop_sample;
    logic byte_ok;
    logic frame_err;

    // Sample/error decode for the current cycle; timeout has priority over a sample
    always_comb begin
        sample      = clk_prev_q & ~clk_f;
        timeout     = (state_q != IDLE) && (to_cnt_q == TO_LAST);
        start_err   = sample && (state_q == IDLE) && data_f;
        stop_sample = sample && (state_q == STOP) && !timeout;
        byte_ok     = stop_sample && data_f && (^{shift_q, parity_q});
        frame_err   = timeout || start_err || (stop_sample && !byte_ok);
    end

    // Frame FSM: start, 8 data bits LSB first, parity, stop, with inactivity timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            clk_prev_q    <= 1'b1;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            parity_q      <= 1'b0;
            to_cnt_q      <= 20'd0;
            frame_error_q <= 1'b0;
        end else begin
            clk_prev_q    <= clk_f;
            frame_error_q <= frame_err;

            if (timeout || (state_q == IDLE) || sample) begin
                to_cnt_q <= 20'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 20'd1;
            end

            if (timeout) begin
                state_q <= IDLE;
            end else if (sample) begin
                case (state_q)
                    IDLE: begin
                        if (!data_f) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_f, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= data_f;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Byte assembler: fold E0/F0 into flags, swallow Pause, emit one toggled event per key
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
            key_q  <= 11'h000;
        end else if (frame_err) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
        end else if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_q <= skip_q - 3'd1;
            end else if (shift_q == PFX_EXT) begin
                ext_q <= 1'b1;
            end else if (shift_q == PFX_BRK) begin
                brk_q <= 1'b1;
            end else if (shift_q == PFX_PAUSE) begin
                skip_q <= PAUSE_SKIP;
            end else if (!is_discard(shift_q)) begin
                key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign ps2.ps2_key     = key_q;
    assign ps2.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

    localparam int FL = 4;
    localparam int TC = 200;
    localparam int H  = 12;

    logic clk;
    logic reset_n;
    int   cyc;

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int          ev_seen, err_seen, long_err, err_cyc, fall_cyc;
    logic [10:0] last_key;
    logic        prev_tog, prev_err;
    bit          mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.frame_error) begin
                err_seen++;
                err_cyc = cyc;
                if (prev_err) long_err++;
            end
            if (bus.ps2_key[10] != prev_tog) begin
                ev_seen++;
                last_key = bus.ps2_key;
            end
        end
        prev_err = bus.frame_error;
        prev_tog = bus.ps2_key[10];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        ev_seen  = 0;
        err_seen = 0;
        long_err = 0;
        err_cyc  = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit bad_start, input bit glitch, input int nbits);
        logic [10:0] bits;
        bits[0]    = bad_start;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ bad_par;
        bits[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            if (glitch && i == 4) begin
                repeat (2) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (FL - 1) @(negedge clk);
                bus.ps2_clk = 1'b1;
                repeat (H - 2 - (FL - 1)) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            bus.ps2_clk = 1'b0;
            fall_cyc = cyc;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (2 * H + FL + 8) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int exp_ev, input logic [10:0] exp_key,
                               input int exp_err);
        check({name, " events"}, ev_seen, exp_ev);
        if (exp_ev == 1) check({name, " key"}, {21'd0, last_key}, {21'd0, exp_key});
        check({name, " errors"}, err_seen, exp_err);
        check({name, " err width"}, long_err, 0);
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        bit          bad_start;
        bit          glitch;
        int          nbits;
        int          exp_ev;
        logic [10:0] exp_key;
        int          exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: the event word is built directly from the decoding rules
    logic       m_tog, m_ext, m_brk;
    int         m_skip;
    logic [7:0] disc_list [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    task automatic model_byte(input logic [7:0] b, input bit good, output int ev,
                              output logic [10:0] key, output int err);
        bit is_disc;
        ev = 0; err = 0; key = 11'h000;
        is_disc = 0;
        foreach (disc_list[k]) if (disc_list[k] == b) is_disc = 1;
        if (!good) begin
            err = 1; m_ext = 0; m_brk = 0; m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (!is_disc) begin
            m_tog = ~m_tog;
            key   = {m_tog, ~m_brk, m_ext, b};
            ev    = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          ev, err, r;
        logic [10:0] key;
        logic [7:0]  b;
        bit          bp;

        //            b      par stp sta gli n   ev key     err
        vecs.push_back('{8'h1C, 0, 0, 0, 0, 11, 1, 11'h61C, 0});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h1C, 0, 0, 0, 0, 11, 1, 11'h01C, 0});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h74, 0, 0, 0, 0, 11, 1, 11'h774, 0});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h74, 0, 0, 0, 0, 11, 1, 11'h174, 0});
        vecs.push_back('{8'h1C, 1, 0, 0, 0, 11, 0, 11'h000, 1});
        vecs.push_back('{8'h1B, 0, 0, 0, 0, 11, 1, 11'h61B, 0});
        vecs.push_back('{8'h1C, 0, 1, 0, 0, 11, 0, 11'h000, 1});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'hAA, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h29, 0, 0, 0, 0, 11, 1, 11'h329, 0});
        vecs.push_back('{8'h1C, 0, 0, 0, 1, 11, 1, 11'h61C, 0});
        vecs.push_back('{8'hE1, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h14, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h77, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'hE1, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h14, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'hF0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h77, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h1C, 0, 0, 0, 0, 11, 1, 11'h21C, 0});
        vecs.push_back('{8'hE0, 0, 0, 0, 0, 11, 0, 11'h000, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 0, 1,  0, 11'h000, 1});
        vecs.push_back('{8'h1C, 0, 0, 0, 0, 11, 1, 11'h61C, 0});

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset_n      = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ps2_key", {21'd0, bus.ps2_key}, 32'h000);
        check("reset frame_error", {31'd0, bus.frame_error}, 32'd0);

        mon_en = 1;
        foreach (vecs[i]) begin
            clear_mon();
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].bad_start,
                       vecs[i].glitch, vecs[i].nbits);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_ev, vecs[i].exp_key, vecs[i].exp_err);
        end

        // Truncated frame after an E0 prefix: timeout error, flags cleared
        clear_mon();
        send_frame(8'hE0, 0, 0, 0, 0, 11);
        send_frame(8'h29, 0, 0, 0, 0, 5);
        repeat (TC + 20) @(negedge clk);
        check("timeout errors", err_seen, 1);
        check("timeout events", ev_seen, 0);
        check("timeout latency", err_cyc - fall_cyc, 3 + FL + TC);
        check("timeout err width", long_err, 0);
        clear_mon();
        send_frame(8'h29, 0, 0, 0, 0, 11);
        check_frame("after timeout", 1, 11'h229, 0);

        // Randomized frames against the reference model
        m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 34) b = 8'hE1;
            else if (r < 44) b = disc_list[$urandom_range(0, 7)];
            else             b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            model_byte(b, !bp, ev, key, err);
            clear_mon();
            send_frame(b, bp, 0, 0, 0, 11);
            check_frame($sformatf("rand%0d b=%0h", n, b), ev, key, err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the raw PS/2 keyboard clock/data pair and turns it into the 11-bit `ps2_key` event word used by the keyboard decoder. It sits between the board's PS/2 pins and the keyboard/console-switch logic, so the rest of the design only ever sees one clean event per make or break. It:
- synchronises and deglitches both lines;
- deserialises 11-bit frames and checks parity;
- folds the E0/F0 prefix bytes into flag bits;
- emits one event word per complete key code.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal samples required before a filtered line changes level (range 2..255).
- `TIMEOUT_CYCLES`, 50000: clk cycles with no PS/2 clock fall inside a frame before the frame is aborted (range 16..2^20-1).

Ports:
- `clk`  in  1: system clock. Reset is asynchronous and active-low.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous, idle high.
- `ps2_data`  in  1: raw PS/2 data pin, asynchronous, idle high.
- `ps2_key`  out  11: event word:
  - [10] toggles once per event;
  - [9] 1 = make, 0 = break;
  - [8] extended (E0) flag;
  - [7:0] scancode.
- `frame_error`  out  1: one-cycle pulse on a parity, start, stop or timeout failure.

## Operation
- Line conditioning, per line:
  - two-flop synchroniser;
  - saturating counter filter: the filtered level takes the new value only after `FILTER_LEN` consecutive synchronised samples differ from the current filtered level;
  - any sample equal to the current level clears the counter.
- A bit sample happens in the cycle where the filtered clock goes 1->0; the filtered data level in that cycle is the bit value.
- Frame FSM:
  - IDLE: on a sample, data=0 -> DATA with bit count 0. Data=1 is a start error: pulse `frame_error`, stay in IDLE.
  - DATA: shift bits in LSB first. After 8 samples -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: on a sample -> IDLE. Byte is valid iff data=1 and the 8 data bits plus the parity bit hold an odd number of ones. Otherwise pulse `frame_error` and discard the byte.
  - Timeout: any non-IDLE state with `TIMEOUT_CYCLES` cycles since the last sample -> IDLE and pulse `frame_error`. The timeout counter clears on every sample and while in IDLE.
- Byte assembler, acting on each valid byte:
  - skip counter nonzero: decrement it, no event.
  - E0: set `ext`.
  - F0: set `brk`.
  - E1: load skip counter with 7 (Pause sequence is swallowed).
  - 00, AA, EE, FA, FC, FD, FE, FF: discard; `ext` and `brk` stay unchanged.
  - any other byte: `ps2_key` <= {~ps2_key[10], ~brk, ext, byte}, then clear `ext` and `brk`.
- Any frame error clears `ext`, `brk` and the skip counter.
- Typematic repeats produce fresh make events (bit 10 toggles each time).

## Timing
- Reset values:
  - `ps2_key` = 11'h000, `frame_error` = 0;
  - FSM in IDLE, all flags and counters 0;
  - filtered and synchroniser levels = 1.
- Reset asserted mid-frame aborts the frame with no event and no error pulse.
- Latency from a raw pin edge to the filtered edge: 2 + `FILTER_LEN` cycles.
- `ps2_key` and `frame_error` update on the clk edge after the STOP-state sample cycle (1-cycle registered latency). `frame_error` is high for exactly one cycle.
- Outputs are registered. `ps2_key` holds its value between events, and only bit 10 is guaranteed to change per event. A consumer detects a new event by comparing bit 10 against its previous value.
- A sample arriving in the same cycle the timeout fires: the timeout wins, FSM -> IDLE, and the sample is not used as a start bit.
- Minimum event spacing is one full frame, more than 11 × `FILTER_LEN` cycles, so no output back-pressure is needed.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - byte constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1;
  - the discard list;
  - PAUSE_SKIP=7.
- Sub-module `ps2_line_filter` (synchroniser plus counter filter, parameter `FILTER_LEN`, reset level 1), instantiated twice.
- The frame FSM and byte assembler live in the top module.

## Test plan
- Frame 0x1C with correct parity -> `ps2_key` goes 11'h000 -> 11'h61C (toggle 1, make, ext 0), with no `frame_error`.
- F0 then 1C -> bit 10 toggles back to 0, [9]=0, [8]=0, [7:0]=1C. The F0 byte alone produces no event.
- E0 74, then E0 F0 74 -> first event {1,1,1,8'h74}, then {0,0,1,8'h74}.
- 0x1C with flipped parity -> no toggle and a single-cycle `frame_error`. A following good 0x1B then gives a make event with ext=0.
- 5 bits sent, then lines idle high -> `frame_error` exactly `TIMEOUT_CYCLES` cycles after the 5th fall. The next full 0x29 frame then decodes correctly.
- Glitches:
  - a pulse of `FILTER_LEN`-1 cycles on `ps2_clk` mid-frame is ignored and the byte decodes correctly;
  - the Pause sequence E1 14 77 E1 F0 14 F0 77 produces no events;
  - a subsequent 0x1C produces exactly one event.
